// File: rtl/mem_access.sv
// Memory-access pipeline stage: latches one load/store from execute, issues a single
// sized data SRAM request with byte lanes, waits for the response and hands off to writeback.
module mem_access (
    input  logic        clk,
    input  logic        reset,
    input  logic        ex_valid,
    output logic        mem_allowin,
    input  logic        MemtoReg,
    input  logic        RegWrite,
    input  logic [1:0]  MemWrite,
    input  logic [1:0]  MemRead,
    input  logic [31:0] Aluout,
    input  logic [31:0] busB,
    input  logic [4:0]  rd,
    output logic        data_sram_req,
    output logic        data_sram_wr,
    output logic [1:0]  data_sram_size,
    output logic [3:0]  data_sram_wstrb,
    output logic [31:0] data_sram_addr,
    output logic [31:0] data_sram_wdata,
    input  logic        data_sram_addr_ok,
    input  logic        data_sram_data_ok,
    input  logic [31:0] data_sram_rdata,
    input  logic        wb_allowin,
    output logic        wb_valid,
    output logic        MemtoReg_out,
    output logic        RegWrite_out,
    output logic [1:0]  MemWrite_out,
    output logic [1:0]  MemRead_out,
    output logic [31:0] Aluout_out,
    output logic [31:0] busB_out,
    output logic [31:0] mem_rdata,
    output logic [4:0]  rd_out,
    output logic [1:0]  addr_excp
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t      state, state_nxt, launch;
    logic        accept;
    logic        in_store, in_memop, in_misalign;
    logic [1:0]  in_width;
    logic        st_store, in_req;
    logic [1:0]  st_width;

    function automatic logic [3:0] lane_strb(input logic [1:0] width, input logic [1:0] a);
        case (width)
            2'b01:   lane_strb = 4'b0001 << a;
            2'b10:   lane_strb = a[1] ? 4'b1100 : 4'b0011;
            default: lane_strb = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] lane_data(input logic [1:0] width, input logic [31:0] src);
        case (width)
            2'b01:   lane_data = {4{src[7:0]}};
            2'b10:   lane_data = {2{src[15:0]}};
            default: lane_data = src;
        endcase
    endfunction

    // Decode of the instruction offered by execute; stores win over loads.
    always_comb begin
        in_store = (MemWrite != 2'b00);
        in_width = in_store ? MemWrite : MemRead;
        in_memop = (in_width != 2'b00);
        case (in_width)
            2'b10:   in_misalign = Aluout[0];
            2'b11:   in_misalign = (Aluout[1:0] != 2'b00);
            default: in_misalign = 1'b0;
        endcase
        launch = (in_memop && !in_misalign) ? REQ : DONE;
    end

    assign mem_allowin = (state == IDLE) || ((state == DONE) && wb_allowin);
    assign accept      = ex_valid && mem_allowin;
    assign wb_valid    = (state == DONE);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = launch;
            REQ:  if (data_sram_addr_ok) state_nxt = data_sram_data_ok ? DONE : WAIT;
            WAIT: if (data_sram_data_ok) state_nxt = DONE;
            DONE: begin
                if (accept)          state_nxt = launch;
                else if (wb_allowin) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Stage registers: misaligned accesses are neutralised at capture time.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= IDLE;
            MemtoReg_out <= 1'b0;
            RegWrite_out <= 1'b0;
            MemWrite_out <= 2'b00;
            MemRead_out  <= 2'b00;
            Aluout_out   <= 32'd0;
            busB_out     <= 32'd0;
            rd_out       <= 5'd0;
            addr_excp    <= 2'b00;
            mem_rdata    <= 32'd0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                MemtoReg_out <= MemtoReg;
                RegWrite_out <= RegWrite && !in_misalign;
                MemWrite_out <= in_misalign ? 2'b00 : MemWrite;
                MemRead_out  <= in_misalign ? 2'b00 : MemRead;
                Aluout_out   <= Aluout;
                busB_out     <= busB;
                rd_out       <= rd;
                addr_excp    <= in_misalign ? (in_store ? 2'b10 : 2'b01) : 2'b00;
                mem_rdata    <= 32'd0;
            end else if (data_sram_data_ok && ((state == REQ) || (state == WAIT))) begin
                mem_rdata <= data_sram_rdata;
            end
        end
    end

    // Request fields come straight from the held instruction, so they stay stable until addr_ok.
    always_comb begin
        st_store        = (MemWrite_out != 2'b00);
        st_width        = st_store ? MemWrite_out : MemRead_out;
        in_req          = (state == REQ);
        data_sram_req   = in_req;
        data_sram_wr    = in_req && st_store;
        data_sram_size  = in_req ? (st_width - 2'd1) : 2'd0;
        data_sram_addr  = in_req ? Aluout_out : 32'd0;
        data_sram_wstrb = (in_req && st_store) ? lane_strb(st_width, Aluout_out[1:0]) : 4'b0000;
        data_sram_wdata = (in_req && st_store) ? lane_data(st_width, busB_out) : 32'd0;
    end

endmodule

// File: tb/tb_mem_access.sv
// Bench for mem_access: directed scenarios plus randomized load/store traffic
// checked against a transaction-level model of the stage.
module tb_mem_access;

    logic        clk, reset, ex_valid, mem_allowin;
    logic        MemtoReg, RegWrite;
    logic [1:0]  MemWrite, MemRead;
    logic [31:0] Aluout, busB;
    logic [4:0]  rd;
    logic        data_sram_req, data_sram_wr;
    logic [1:0]  data_sram_size;
    logic [3:0]  data_sram_wstrb;
    logic [31:0] data_sram_addr, data_sram_wdata;
    logic        data_sram_addr_ok, data_sram_data_ok;
    logic [31:0] data_sram_rdata;
    logic        wb_allowin, wb_valid;
    logic        MemtoReg_out, RegWrite_out;
    logic [1:0]  MemWrite_out, MemRead_out;
    logic [31:0] Aluout_out, busB_out, mem_rdata;
    logic [4:0]  rd_out;
    logic [1:0]  addr_excp;

    int checks = 0;
    int errors = 0;

    mem_access dut (
        .clk(clk), .reset(reset), .ex_valid(ex_valid), .mem_allowin(mem_allowin),
        .MemtoReg(MemtoReg), .RegWrite(RegWrite), .MemWrite(MemWrite), .MemRead(MemRead),
        .Aluout(Aluout), .busB(busB), .rd(rd),
        .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr),
        .data_sram_size(data_sram_size), .data_sram_wstrb(data_sram_wstrb),
        .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
        .data_sram_addr_ok(data_sram_addr_ok), .data_sram_data_ok(data_sram_data_ok),
        .data_sram_rdata(data_sram_rdata),
        .wb_allowin(wb_allowin), .wb_valid(wb_valid),
        .MemtoReg_out(MemtoReg_out), .RegWrite_out(RegWrite_out),
        .MemWrite_out(MemWrite_out), .MemRead_out(MemRead_out),
        .Aluout_out(Aluout_out), .busB_out(busB_out), .mem_rdata(mem_rdata),
        .rd_out(rd_out), .addr_excp(addr_excp)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL timeout got running exp finished");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // One complete instruction through the stage. ad = extra cycles before addr_ok,
    // dd = cycles from addr_ok to data_ok, hold = cycles writeback stalls.
    task automatic do_op(input logic [1:0] mw, input logic [1:0] mr, input logic [31:0] addr,
                         input logic [31:0] bval, input logic m2r, input logic rw,
                         input logic [4:0] rdv, input int ad, input int dd, input int hold);
        logic        st, mis, ereq;
        logic [1:0]  w, exc;
        int          nbytes;
        logic [3:0]  estrb;
        logic [31:0] ewd, rv;
        st     = (mw != 2'b00);
        w      = st ? mw : mr;
        nbytes = (w == 2'b00) ? 0 : (1 << (int'(w) - 1));
        mis    = (nbytes != 0) && ((int'(addr[1:0]) % nbytes) != 0);
        ereq   = (nbytes != 0) && !mis;
        exc    = mis ? (st ? 2'b10 : 2'b01) : 2'b00;
        estrb  = st ? 4'(((1 << nbytes) - 1) << addr[1:0]) : 4'b0000;
        ewd    = 32'd0;
        if (st)
            for (int i = 0; i < 4; i++) ewd[8*i +: 8] = bval[8*(i % nbytes) +: 8];
        rv = $urandom;

        @(negedge clk);
        ex_valid = 1'b1; MemWrite = mw; MemRead = mr; Aluout = addr; busB = bval;
        MemtoReg = m2r; RegWrite = rw; rd = rdv; wb_allowin = 1'b0;
        #1 chk("allowin_idle", 32'(mem_allowin), 32'd1);
        @(negedge clk);
        ex_valid = 1'b0; MemWrite = 2'($urandom); MemRead = 2'($urandom);
        Aluout = $urandom; busB = $urandom; rd = 5'($urandom);
        if (ereq) begin
            for (int k = 0; k <= ad; k++) begin
                if (k > 0) @(negedge clk);
                data_sram_addr_ok = (k == ad);
                data_sram_data_ok = (k == ad) && (dd == 0);
                data_sram_rdata   = (k == ad && dd == 0) ? rv : $urandom;
                #1;
                chk("req", 32'(data_sram_req), 32'd1);
                chk("wr", 32'(data_sram_wr), 32'(st));
                chk("size", 32'(data_sram_size), 32'(w - 2'd1));
                chk("wstrb", 32'(data_sram_wstrb), 32'(estrb));
                chk("addr", data_sram_addr, addr);
                chk("wdata", data_sram_wdata, ewd);
                chk("wbv_req", 32'(wb_valid), 32'd0);
            end
            for (int j = 1; j <= dd; j++) begin
                @(negedge clk);
                data_sram_addr_ok = 1'b0;
                data_sram_data_ok = (j == dd);
                data_sram_rdata   = (j == dd) ? rv : $urandom;
                #1 chk("req_wait", 32'(data_sram_req), 32'd0);
            end
            @(negedge clk);
            data_sram_addr_ok = 1'b0; data_sram_data_ok = 1'b0;
        end else begin
            #1 chk("noreq", 32'(data_sram_req), 32'd0);
        end
        for (int h = 0; h <= hold; h++) begin
            if (h > 0) @(negedge clk);
            wb_allowin        = (h == hold);
            data_sram_addr_ok = 1'($urandom);
            data_sram_data_ok = 1'($urandom);
            data_sram_rdata   = $urandom;
            #1;
            chk("wb_valid", 32'(wb_valid), 32'd1);
            chk("allowin_done", 32'(mem_allowin), 32'(h == hold));
            chk("m2r_out", 32'(MemtoReg_out), 32'(m2r));
            chk("rw_out", 32'(RegWrite_out), 32'(rw && !mis));
            chk("mw_out", 32'(MemWrite_out), 32'(mis ? 2'b00 : mw));
            chk("mr_out", 32'(MemRead_out), 32'(mis ? 2'b00 : mr));
            chk("alu_out", Aluout_out, addr);
            chk("busb_out", busB_out, bval);
            chk("rd_out", 32'(rd_out), 32'(rdv));
            chk("excp", 32'(addr_excp), 32'(exc));
            if (ereq) chk("mem_rdata", mem_rdata, rv);
        end
        @(negedge clk);
        data_sram_addr_ok = 1'b0; data_sram_data_ok = 1'b0;
        #1;
        chk("wbv_drained", 32'(wb_valid), 32'd0);
        chk("allowin_drained", 32'(mem_allowin), 32'd1);
    endtask

    initial begin
        reset = 1'b0; ex_valid = 1'b0; MemtoReg = 1'b0; RegWrite = 1'b0;
        MemWrite = 2'b00; MemRead = 2'b00; Aluout = 32'd0; busB = 32'd0; rd = 5'd0;
        data_sram_addr_ok = 1'b0; data_sram_data_ok = 1'b0; data_sram_rdata = 32'd0;
        wb_allowin = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_req", 32'(data_sram_req), 32'd0);
        chk("rst_wstrb", 32'(data_sram_wstrb), 32'd0);
        chk("rst_addr", data_sram_addr, 32'd0);
        chk("rst_wdata", data_sram_wdata, 32'd0);
        chk("rst_wbv", 32'(wb_valid), 32'd0);
        chk("rst_rdata", mem_rdata, 32'd0);
        chk("rst_alu", Aluout_out, 32'd0);
        chk("rst_excp", 32'(addr_excp), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        #1 chk("allowin_after_rst", 32'(mem_allowin), 32'd1);

        // Store byte to 0x1003, then check the lane pattern explicitly too.
        do_op(2'b01, 2'b00, 32'h1003, 32'h0000_00AB, 1'b0, 1'b0, 5'd3, 0, 0, 0);
        // Load word with delayed handshakes.
        do_op(2'b00, 2'b11, 32'h0000_2000, 32'h0, 1'b1, 1'b1, 5'd7, 2, 2, 1);
        // Misaligned half load.
        do_op(2'b00, 2'b10, 32'h0000_2001, 32'h0, 1'b1, 1'b1, 5'd9, 0, 0, 0);
        // Store half to upper lanes.
        do_op(2'b10, 2'b00, 32'h0000_0012, 32'h1234_ABCD, 1'b0, 1'b0, 5'd1, 1, 0, 2);
        // Misaligned word store with a conflicting read code.
        do_op(2'b11, 2'b01, 32'h0000_0102, 32'h5555_AAAA, 1'b0, 1'b1, 5'd4, 0, 0, 0);

        // Directed lane check for a byte store at offset 3.
        @(negedge clk);
        ex_valid = 1'b1; MemWrite = 2'b01; MemRead = 2'b00; Aluout = 32'h1003;
        busB = 32'h0000_00AB; wb_allowin = 1'b1;
        @(negedge clk);
        ex_valid = 1'b0; data_sram_addr_ok = 1'b1; data_sram_data_ok = 1'b1;
        #1;
        chk("sb_wstrb", 32'(data_sram_wstrb), 32'h8);
        chk("sb_wdata", data_sram_wdata, 32'hABAB_ABAB);
        @(negedge clk);
        data_sram_addr_ok = 1'b0; data_sram_data_ok = 1'b0;
        #1 chk("sb_wbv", 32'(wb_valid), 32'd1);
        @(negedge clk);

        // Back-to-back ALU ops, then a two-cycle writeback stall.
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            ex_valid = 1'b1; MemWrite = 2'b00; MemRead = 2'b00; RegWrite = 1'b1;
            Aluout = $urandom; rd = 5'(i + 1); wb_allowin = 1'b1;
            #1;
            chk("b2b_allowin", 32'(mem_allowin), 32'd1);
            if (i > 0) begin
                chk("b2b_wbv", 32'(wb_valid), 32'd1);
                chk("b2b_rd", 32'(rd_out), 32'(i));
            end
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            ex_valid = 1'b1; rd = 5'(20 + i); wb_allowin = 1'b0;
            #1;
            chk("stall_allowin", 32'(mem_allowin), 32'd0);
            chk("stall_wbv", 32'(wb_valid), 32'd1);
            chk("stall_rd", 32'(rd_out), 32'd6);
        end
        @(negedge clk);
        ex_valid = 1'b0; wb_allowin = 1'b1;
        #1 chk("stall_rel_rd", 32'(rd_out), 32'd6);
        @(negedge clk);
        #1 chk("b2b_drained", 32'(wb_valid), 32'd0);

        // Reset while waiting for data, then a stale data_ok.
        @(negedge clk);
        ex_valid = 1'b1; MemWrite = 2'b00; MemRead = 2'b11; Aluout = 32'h0000_4000;
        wb_allowin = 1'b0;
        @(negedge clk);
        ex_valid = 1'b0; data_sram_addr_ok = 1'b1; data_sram_data_ok = 1'b0;
        #1 chk("rw_req", 32'(data_sram_req), 32'd1);
        @(negedge clk);
        data_sram_addr_ok = 1'b0; reset = 1'b0;
        #1 chk("rw_wait_req", 32'(data_sram_req), 32'd0);
        @(negedge clk);
        reset = 1'b1; data_sram_data_ok = 1'b1; data_sram_rdata = 32'hCAFE_F00D;
        #1;
        chk("rw_wbv", 32'(wb_valid), 32'd0);
        chk("rw_rdata", mem_rdata, 32'd0);
        chk("rw_allowin", 32'(mem_allowin), 32'd1);
        @(negedge clk);
        data_sram_data_ok = 1'b0;
        #1;
        chk("rw_wbv2", 32'(wb_valid), 32'd0);
        chk("rw_rdata2", mem_rdata, 32'd0);

        // Randomized traffic.
        for (int n = 0; n < 60; n++) begin
            logic [1:0] mw, mr;
            mw = ($urandom_range(0, 2) == 0) ? 2'($urandom) : 2'b00;
            mr = 2'($urandom);
            do_op(mw, mr, $urandom, $urandom, 1'($urandom), 1'($urandom), 5'($urandom),
                  $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
